mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory (1-cycle read latency) between the CPU instruction-fetch port and the load/store data port.
- Sits between the pipelined CPU (iaddr/idata, daddr/drdata/dwdata/we) and a unified memory, so the CPU can run on a single RAM.
- Grants one access per cycle: data has priority, with an anti-starvation limit for fetch.
- Returns read data one cycle after grant, tagged to the owning port.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be 32.
- MAX_D_STREAK, 4, maximum consecutive data grants while fetch is waiting; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request.
- i_addr  in  AW  fetch byte address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  i_rdata valid.
- i_rdata  out  DW  fetched word.
- d_req  in  1  data request.
- d_addr  in  AW  data byte address.
- d_we  in  4  byte write enables; 0 means read.
- d_wdata  in  DW  store data.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  data access complete; d_rdata valid for reads.
- d_rdata  out  DW  load word.
- m_en  out  1  memory access strobe.
- m_addr  out  AW  memory byte address.
- m_we  out  4  memory byte write enables.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data, valid one cycle after an m_en read.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Grant logic is combinational and issued in the same cycle as the request. A request is accepted when its gnt is high. A requester holds req, addr, we and wdata stable until it sees gnt.
- Arbitration:
  - Only one request: it is granted.
  - Both requests and d_streak < MAX_D_STREAK: d_gnt.
  - Both requests and d_streak == MAX_D_STREAK: i_gnt.
  - Neither request: no grant, m_en = 0.
- Streak counter d_streak (4-bit, registered):
  - +1 on each d_gnt, saturating at MAX_D_STREAK.
  - Cleared to 0 on i_gnt, and on any cycle with no d_gnt.
- Memory drive:
  - m_en = i_gnt | d_gnt.
  - m_addr = the granted port's address.
  - m_we = d_we when d_gnt, else 0.
  - m_wdata = d_wdata.
  - m_addr, m_we and m_wdata are 0 when m_en = 0.
- Response registers, loaded at the edge after the grant cycle:
  - owner_q records which port was granted.
  - i_rvalid = registered i_gnt.
  - d_rvalid = registered d_gnt; a store also gets d_rvalid as its acknowledge.
  - i_rdata and d_rdata pass m_rdata through combinationally. Each is gated to 0 unless its own rvalid is high.
- Latency: read data arrives 1 cycle after grant. Back-to-back grants give a throughput of one access per cycle.
- Simultaneous grant and response: a new grant in cycle N+1 coexists with the response to the cycle-N grant. No bubble is inserted.
- Reset: while reset is high, all grants are 0 and m_en = 0. At the edge, d_streak, owner_q, i_rvalid and d_rvalid clear to 0. All outputs read 0 in the cycle after reset.
- Reset mid-operation: if reset is high at the edge following a grant, that response is dropped (no rvalid). A store granted in that cycle still reached memory.
- Misaligned addresses are passed through unchanged; alignment is the CPU's responsibility.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, three 32-bit output ports are added:
  - conflict_cnt: counts cycles with i_req & d_req.
  - i_wait_cnt: counts cycles with i_req & ~i_gnt.
  - starve_cnt: counts forced fetch grants at d_streak == MAX_D_STREAK.
- The counters clear on reset and wrap modulo 2^32.
- When undefined, the ports and logic are absent and the arbitration behaviour is identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - owner encoding constants OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2;
  - the default MAX_D_STREAK;
  - the WE_NONE = 4'b0000 constant.
- One natural sub-module, mem_arb_grant: the combinational priority and streak-compare logic. It takes i_req, d_req and d_streak and returns i_gnt and d_gnt.
- Registers and the memory mux stay in the top level.

Test Plan:
- Fetch only, i_addr 0x0, 0x4, 0x8 on consecutive cycles, memory preloaded with 0x11, 0x22, 0x33 -> i_gnt=1 each cycle; i_rvalid with i_rdata 0x11, 0x22, 0x33 one cycle later; d_rvalid=0 throughout.
- Both requesting for 10 cycles, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; d_streak returns to 0 after each I grant.
- Store d_addr 0x100, d_we 4'b0011, d_wdata 0xAABBCCDD over old 0x12345678, then load 0x100 -> d_rvalid on both accesses; load returns 0x1234CCDD.
- Load granted at cycle N, reset high at cycle N+1 -> d_rvalid stays 0; all outputs 0 the cycle after; first post-reset fetch is granted normally.
- Fetch in cycle N, load in cycle N+1 -> i_rvalid at N+1 and d_rvalid at N+2, with correct data on each port and no cross-talk (d_rdata=0 at N+1).
- With MEM_ARB_PERF_EN, 6 cycles of both requesting -> conflict_cnt=6, i_wait_cnt=5, starve_cnt=1 (with MAX_D_STREAK=4).

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam int unsigned MAX_D_STREAK_DEF = 4;
    localparam logic [3:0]  WE_NONE          = 4'b0000;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational priority: data wins unless fetch has waited through a full data streak.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic       i_req,
    input  logic       d_req,
    input  logic [3:0] d_streak,
    output logic       i_gnt,
    output logic       d_gnt
);

    logic at_limit;

    always_comb begin
        at_limit = (d_streak == 4'(MAX_D_STREAK));
        d_gnt    = d_req & ~(i_req & at_limit);
        i_gnt    = i_req & ~d_gnt;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between CPU fetch and load/store ports.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic [3:0]    d_we,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic [AW-1:0] m_addr,
    output logic [3:0]    m_we,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]   conflict_cnt,
    output logic [31:0]   i_wait_cnt,
    output logic [31:0]   starve_cnt
`endif
);

    logic       i_req_v, d_req_v;
    logic [3:0] d_streak_q, d_streak_d;
    owner_e     owner_q, owner_d;

    assign i_req_v = i_req & ~reset;
    assign d_req_v = d_req & ~reset;

    mem_arb_grant #(.MAX_D_STREAK(MAX_D_STREAK)) u_grant (
        .i_req    (i_req_v),
        .d_req    (d_req_v),
        .d_streak (d_streak_q),
        .i_gnt    (i_gnt),
        .d_gnt    (d_gnt)
    );

    always_comb begin
        d_streak_d = '0;
        owner_d    = OWN_NONE;
        if (d_gnt) begin
            d_streak_d = (d_streak_q >= 4'(MAX_D_STREAK)) ? 4'(MAX_D_STREAK)
                                                          : d_streak_q + 4'd1;
            owner_d    = OWN_D;
        end else if (i_gnt) begin
            owner_d    = OWN_I;
        end
    end

    always_comb begin
        m_en    = i_gnt | d_gnt;
        m_addr  = '0;
        m_we    = WE_NONE;
        m_wdata = '0;
        if (d_gnt) begin
            m_addr  = d_addr;
            m_we    = d_we;
            m_wdata = d_wdata;
        end else if (i_gnt) begin
            m_addr  = i_addr;
            m_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_streak_q <= '0;
            owner_q    <= OWN_NONE;
        end else begin
            d_streak_q <= d_streak_d;
            owner_q    <= owner_d;
        end
    end

    // rvalid is masked while reset is high so a response already in flight is dropped.
    assign i_rvalid = (owner_q == OWN_I) & ~reset;
    assign d_rvalid = (owner_q == OWN_D) & ~reset;
    assign i_rdata  = i_rvalid ? m_rdata : '0;
    assign d_rdata  = d_rvalid ? m_rdata : '0;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] conflict_q, i_wait_q, starve_q;
    logic        starve_ev;

    assign starve_ev = i_gnt & d_req_v & (d_streak_q == 4'(MAX_D_STREAK));

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= '0;
            i_wait_q   <= '0;
            starve_q   <= '0;
        end else begin
            if (i_req & d_req)  conflict_q <= conflict_q + 32'd1;
            if (i_req & ~i_gnt) i_wait_q   <= i_wait_q + 32'd1;
            if (starve_ev)      starve_q   <= starve_q + 32'd1;
        end
    end

    assign conflict_cnt = conflict_q;
    assign i_wait_cnt   = i_wait_q;
    assign starve_cnt   = starve_q;
`endif

endmodule
